// File: rtl/data_sync_pkg.sv
// Shared constants and helpers for the multi-channel destination-side data synchroniser.
package data_sync_pkg;

    localparam int MIN_STAGES  = 2;
    localparam int MODE_LEVEL  = 0;
    localparam int MODE_TOGGLE = 1;

    // Bit offset of channel c inside a packed multi-channel bus.
    function automatic int ch_offset(input int c, input int width);
        return c * width;
    endfunction

endpackage

// File: rtl/data_sync_ch.sv
// One channel: enable synchroniser chain, event detect, data capture and valid/overrun tracking.
module data_sync_ch
    import data_sync_pkg::*;
#(
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_STAGES  = 2,
    parameter int TOGGLE_MODE = MODE_LEVEL
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [BUS_WIDTH-1:0] bus_i,
    input  logic                 en_i,
    input  logic                 ready_i,
    input  logic                 ovr_clr_i,
    output logic [BUS_WIDTH-1:0] bus_o,
    output logic                 pulse_o,
    output logic                 valid_o,
    output logic                 overrun_o
);

    if (NUM_STAGES < MIN_STAGES) begin : g_bad_stages
        $error("data_sync_ch: NUM_STAGES must be >= 2");
    end
    if (TOGGLE_MODE != MODE_LEVEL && TOGGLE_MODE != MODE_TOGGLE) begin : g_bad_mode
        $error("data_sync_ch: TOGGLE_MODE must be 0 or 1");
    end

    logic [NUM_STAGES-1:0] sync_q, sync_d;
    logic                  prev_q, prev_d;
    logic [BUS_WIDTH-1:0]  data_q, data_d;
    logic                  pulse_q, pulse_d;
    logic                  valid_q, valid_d;
    logic                  ovr_q, ovr_d;
    logic                  sync_s;
    logic                  ev;

    // Handshake: data is transferred on every edge where valid_o & ready_i; valid_o never
    // drops without that transfer, and a new event replaces unconsumed data (flagging overrun).
    always_comb begin
        sync_d  = {sync_q[NUM_STAGES-2:0], en_i};
        sync_s  = sync_q[NUM_STAGES-1];
        prev_d  = sync_s;
        ev      = (TOGGLE_MODE == MODE_TOGGLE) ? (sync_s ^ prev_q) : (sync_s & ~prev_q);
        pulse_d = ev;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (ovr_clr_i) begin
            ovr_d = 1'b0;
        end

        if (ev) begin
            data_d  = bus_i;
            valid_d = 1'b1;
            if (valid_q && !ready_i) begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            data_q  <= '0;
            pulse_q <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            data_q  <= data_d;
            pulse_q <= pulse_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus_o     = data_q;
    assign pulse_o   = pulse_q;
    assign valid_o   = valid_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/multi_ch_data_sync.sv
// Multi-channel data synchroniser: slices the packed buses and replicates one channel per lane.
module multi_ch_data_sync
    import data_sync_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_STAGES  = 2,
    parameter int TOGGLE_MODE = MODE_LEVEL
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_CH*BUS_WIDTH-1:0] Unsync_bus,
    input  logic [NUM_CH-1:0]           bus_enable,
    output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
    output logic [NUM_CH-1:0]           enable_pulse,
    output logic [NUM_CH-1:0]           sync_valid,
    input  logic [NUM_CH-1:0]           sync_ready,
    output logic [NUM_CH-1:0]           overrun,
    input  logic                        overrun_clr
);

    if (NUM_CH < 1) begin : g_bad_ch
        $error("multi_ch_data_sync: NUM_CH must be >= 1");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        data_sync_ch #(
            .BUS_WIDTH   (BUS_WIDTH),
            .NUM_STAGES  (NUM_STAGES),
            .TOGGLE_MODE (TOGGLE_MODE)
        ) u_ch (
            .clk_i     (CLK),
            .rst_i     (RST),
            .bus_i     (Unsync_bus[ch_offset(c, BUS_WIDTH) +: BUS_WIDTH]),
            .en_i      (bus_enable[c]),
            .ready_i   (sync_ready[c]),
            .ovr_clr_i (overrun_clr),
            .bus_o     (sync_bus[ch_offset(c, BUS_WIDTH) +: BUS_WIDTH]),
            .pulse_o   (enable_pulse[c]),
            .valid_o   (sync_valid[c]),
            .overrun_o (overrun[c])
        );
    end

endmodule
